// File: rtl/fixed_point_sqrt_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fixed_point_sqrt_seq_pkg
//  Description : Shared definitions for the sequential fixed-point square-root
//                unit: FSM state encoding and round-mode constants.
//  Revision    : 1.0  initial release
// ============================================================================
package fixed_point_sqrt_seq_pkg;

    // Controller states of the square-root unit.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ITER  = 2'd1,
        ST_ROUND = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Per-operation rounding selection (iRoundMode encoding).
    localparam logic C_ROUND_TRUNC   = 1'b0;
    localparam logic C_ROUND_NEAREST = 1'b1;

endpackage
`default_nettype wire

// File: rtl/sqrt_restore_step.sv
`default_nettype none
// ============================================================================
//  Module      : sqrt_restore_step
//  Description : One step of the restoring digit-by-digit square root.
//                Brings down the next radicand bit pair, compares the partial
//                remainder against the trial value (root<<2)|1 and produces
//                the next remainder and root (one new root bit).
//  Revision    : 1.0  initial release
//
//  Ports
//    iRemainder  in  OUT_WIDTH+2  partial remainder before this step
//    iRoot       in  OUT_WIDTH    partial root before this step
//    iPair       in  2            next two radicand bits (MSB pair first)
//    oRemainder  out OUT_WIDTH+2  partial remainder after this step
//    oRoot       out OUT_WIDTH    partial root after this step
// ============================================================================
module sqrt_restore_step #(
    parameter int OUT_WIDTH = 32
) (
    input  logic [OUT_WIDTH+1:0] iRemainder,
    input  logic [OUT_WIDTH-1:0] iRoot,
    input  logic [1:0]           iPair,
    output logic [OUT_WIDTH+1:0] oRemainder,
    output logic [OUT_WIDTH-1:0] oRoot
);

    logic [OUT_WIDTH+1:0] w_shifted;
    logic [OUT_WIDTH+1:0] w_trial;
    logic                 w_fits;
    logic                 w_unused_rem_msbs;

    // The incoming remainder never exceeds 2*root of a root that still has at
    // most OUT_WIDTH-1 significant bits, so its two MSBs are always zero and
    // can be shifted out without loss.
    assign w_shifted         = {iRemainder[OUT_WIDTH-1:0], iPair};
    assign w_unused_rem_msbs = |iRemainder[OUT_WIDTH+1:OUT_WIDTH];

    assign w_trial    = {iRoot, 2'b01};
    assign w_fits     = (w_shifted >= w_trial);

    assign oRemainder = w_fits ? (w_shifted - w_trial) : w_shifted;
    assign oRoot      = {iRoot[OUT_WIDTH-2:0], w_fits};

endmodule
`default_nettype wire

// File: rtl/fixed_point_sqrt_seq.sv
`default_nettype none
// ============================================================================
//  Module      : fixed_point_sqrt_seq
//  Description : Sequential unsigned fixed-point square root. An IN_WIDTH-bit
//                radicand yields an IN_WIDTH/2-bit root, one root bit per
//                cycle, with optional round-to-nearest, an inexact flag and
//                valid/accept handshakes on both sides.
//  Revision    : 1.0  initial release
//
//  Ports
//    Clock          in   1            rising-edge clock
//    Reset          in   1            asynchronous, active-low reset
//    iOperand       in   IN_WIDTH     unsigned radicand (sampled on accept)
//    iRoundMode     in   1            0 truncate, 1 round-to-nearest
//    iInputValid    in   1            upstream offers an operand
//    oInputAccept   out  1            unit idle, takes an operand this cycle
//    oOutputValid   out  1            oResult / oInexact are valid
//    iOutputAccept  in   1            downstream consumes the result
//    oResult        out  IN_WIDTH/2   root
//    oInexact       out  1            final (unrounded) remainder is nonzero
//
//  IN_WIDTH must be even and at least 4.
// ============================================================================
module fixed_point_sqrt_seq
    import fixed_point_sqrt_seq_pkg::*;
#(
    parameter int IN_WIDTH = 64
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic [IN_WIDTH-1:0]   iOperand,
    input  logic                  iRoundMode,
    input  logic                  iInputValid,
    output logic                  oInputAccept,
    output logic                  oOutputValid,
    input  logic                  iOutputAccept,
    output logic [IN_WIDTH/2-1:0] oResult,
    output logic                  oInexact
);

    localparam int OUT_WIDTH = IN_WIDTH / 2;
    localparam int REM_WIDTH = OUT_WIDTH + 2;
    localparam int CNT_WIDTH = $clog2(OUT_WIDTH);

    state_t                 r_state;
    state_t                 w_state_next;

    logic [IN_WIDTH-1:0]    r_radicand;
    logic                   r_round_mode;
    logic [OUT_WIDTH-1:0]   r_root;
    logic [REM_WIDTH-1:0]   r_rem;
    logic [CNT_WIDTH-1:0]   r_count;

    logic [REM_WIDTH-1:0]   w_step_rem;
    logic [OUT_WIDTH-1:0]   w_step_root;
    logic                   w_round_up;

    // ------------------------------------------------------------------------
    // Recurrence step on the current MSB pair of the radicand shift register
    // ------------------------------------------------------------------------
    sqrt_restore_step #(
        .OUT_WIDTH (OUT_WIDTH)
    ) u_step (
        .iRemainder (r_rem),
        .iRoot      (r_root),
        .iPair      (r_radicand[IN_WIDTH-1 -: 2]),
        .oRemainder (w_step_rem),
        .oRoot      (w_step_root)
    );

    // Remainder = x - r^2; rounding up is right exactly when x > r^2 + r,
    // i.e. remainder > root, since (r+1/2)^2 = r^2 + r + 1/4. An all-ones
    // root saturates instead of wrapping.
    assign w_round_up = (r_rem > {2'b00, r_root}) && !(&r_root);

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (iInputValid) begin
                    w_state_next = ST_ITER;
                end
            end
            ST_ITER: begin
                if (r_count == '0) begin
                    w_state_next = (r_round_mode == C_ROUND_NEAREST) ? ST_ROUND : ST_DONE;
                end
            end
            ST_ROUND: begin
                w_state_next = ST_DONE;
            end
            ST_DONE: begin
                if (iOutputAccept) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath: radicand shift register, root, remainder, step counter
    // ------------------------------------------------------------------------
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_radicand   <= '0;
            r_round_mode <= C_ROUND_TRUNC;
            r_root       <= '0;
            r_rem        <= '0;
            r_count      <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (iInputValid) begin
                        r_radicand   <= iOperand;
                        r_round_mode <= iRoundMode;
                        r_root       <= '0;
                        r_rem        <= '0;
                        r_count      <= CNT_WIDTH'(OUT_WIDTH - 1);
                    end
                end
                ST_ITER: begin
                    r_radicand <= r_radicand << 2;
                    r_root     <= w_step_root;
                    r_rem      <= w_step_rem;
                    r_count    <= r_count - 1'b1;
                end
                ST_ROUND: begin
                    // Remainder is left untouched so the inexact flag still
                    // reflects the unrounded result.
                    if (w_round_up) begin
                        r_root <= r_root + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Outputs: pure decodes of registered state
    // ------------------------------------------------------------------------
    assign oInputAccept = (r_state == ST_IDLE);
    assign oOutputValid = (r_state == ST_DONE);
    assign oResult      = r_root;
    assign oInexact     = |r_rem;

endmodule
`default_nettype wire

// File: tb/tb_fixed_point_sqrt_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fixed_point_sqrt_seq
//  Description : Self-checking bench for fixed_point_sqrt_seq. Runs a 64-bit
//                and a 16-bit instance against a behavioural square-root and
//                handshake model, plus directed literal cases.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fixed_point_sqrt_seq;

    logic Clock = 1'b0;
    logic Reset = 1'b0;
    always #5 Clock = ~Clock;

    // index 0: 64-bit instance, index 1: 16-bit instance
    logic        in_valid [2];
    logic        in_mode  [2];
    logic        out_acc  [2];
    logic [63:0] op64;
    logic [15:0] op16;

    logic        iacc64, oval64, inx64;
    logic        iacc16, oval16, inx16;
    logic [31:0] res64;
    logic [7:0]  res16;

    fixed_point_sqrt_seq #(.IN_WIDTH(64)) u_dut64 (
        .Clock        (Clock),
        .Reset        (Reset),
        .iOperand     (op64),
        .iRoundMode   (in_mode[0]),
        .iInputValid  (in_valid[0]),
        .oInputAccept (iacc64),
        .oOutputValid (oval64),
        .iOutputAccept(out_acc[0]),
        .oResult      (res64),
        .oInexact     (inx64)
    );

    fixed_point_sqrt_seq #(.IN_WIDTH(16)) u_dut16 (
        .Clock        (Clock),
        .Reset        (Reset),
        .iOperand     (op16),
        .iRoundMode   (in_mode[1]),
        .iInputValid  (in_valid[1]),
        .oInputAccept (iacc16),
        .oOutputValid (oval16),
        .iOutputAccept(out_acc[1]),
        .oResult      (res16),
        .oInexact     (inx16)
    );

    int checks = 0;
    int errors = 0;
    bit stop16 = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------------
    // Reference arithmetic
    // ------------------------------------------------------------------------
    function automatic logic [31:0] isqrt_floor(input logic [63:0] x);
        logic [63:0] lo, hi, mid;
        lo = 64'd0;
        hi = 64'hFFFF_FFFF;
        while (lo < hi) begin
            mid = lo + ((hi - lo + 64'd1) >> 1);
            if (mid * mid <= x) lo = mid;
            else                hi = mid - 64'd1;
        end
        return lo[31:0];
    endfunction

    // Nearest: round up when sqrt(x) >= r + 1/2, i.e. 4x >= (2r+1)^2.
    function automatic logic [31:0] model_root(input logic [63:0] x, input logic mode, input int ow);
        logic [31:0] r;
        logic [31:0] maxr;
        logic [67:0] four_x;
        logic [67:0] odd;
        r      = isqrt_floor(x);
        maxr   = 32'hFFFF_FFFF >> (32 - ow);
        four_x = {4'b0000, x} << 2;
        odd    = 68'(r) * 68'd2 + 68'd1;
        if (mode && (four_x >= odd * odd) && (r != maxr)) r = r + 32'd1;
        return r;
    endfunction

    function automatic logic model_inexact(input logic [63:0] x);
        logic [63:0] r;
        r = {32'h0, isqrt_floor(x)};
        return (r * r) != x;
    endfunction

    function automatic logic [63:0] rand64();
        logic [63:0] r;
        case ($urandom % 6)
            0: begin r = {32'h0, $urandom}; return r * r; end
            1: return 64'hFFFF_FFFF_FFFF_FFFF - 64'($urandom % 4);
            2: return 64'($urandom % 1024);
            default: return {$urandom, $urandom};
        endcase
    endfunction

    function automatic logic [15:0] rand16();
        logic [15:0] r;
        case ($urandom % 5)
            0: begin r = 16'($urandom % 256); return r * r; end
            1: return 16'hFFFF - 16'($urandom % 4);
            default: return 16'($urandom);
        endcase
    endfunction

    // ------------------------------------------------------------------------
    // Behavioural handshake model: idle -> busy for latency edges -> done
    // ------------------------------------------------------------------------
    int          m_phase [2];   // 0 idle, 1 computing, 2 holding result
    int          m_cnt   [2];
    logic [31:0] m_res   [2];
    logic        m_inx   [2];
    int          m_completed [2];

    always @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            for (int k = 0; k < 2; k++) begin
                m_phase[k] <= 0;
                m_cnt[k]   <= 0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                case (m_phase[k])
                    0: if (in_valid[k]) begin
                        m_phase[k] <= 1;
                        m_cnt[k]   <= (k == 0 ? 32 : 8) + (in_mode[k] ? 1 : 0);
                        m_res[k]   <= model_root(k == 0 ? op64 : {48'h0, op16}, in_mode[k], k == 0 ? 32 : 8);
                        m_inx[k]   <= model_inexact(k == 0 ? op64 : {48'h0, op16});
                    end
                    1: begin
                        if (m_cnt[k] == 1) m_phase[k] <= 2;
                        m_cnt[k] <= m_cnt[k] - 1;
                    end
                    default: if (out_acc[k]) begin
                        m_phase[k]     <= 0;
                        m_completed[k] <= m_completed[k] + 1;
                    end
                endcase
            end
        end
    end

    // Compare process: every cycle, away from the active edge.
    always @(negedge Clock) begin
        chk("iacc64", {63'h0, iacc64}, {63'h0, m_phase[0] == 0});
        chk("oval64", {63'h0, oval64}, {63'h0, m_phase[0] == 2});
        if (m_phase[0] == 2) begin
            chk("res64", {32'h0, res64}, {32'h0, m_res[0]});
            chk("inx64", {63'h0, inx64}, {63'h0, m_inx[0]});
        end
        chk("iacc16", {63'h0, iacc16}, {63'h0, m_phase[1] == 0});
        chk("oval16", {63'h0, oval16}, {63'h0, m_phase[1] == 2});
        if (m_phase[1] == 2) begin
            chk("res16", {56'h0, res16}, {32'h0, m_res[1]});
            chk("inx16", {63'h0, inx16}, {63'h0, m_inx[1]});
        end
    end

    // ------------------------------------------------------------------------
    // Directed operation on the 64-bit instance (call at a negedge)
    // ------------------------------------------------------------------------
    task automatic run_op(input logic [63:0] x, input logic mode, input logic [31:0] exp_res,
                          input logic exp_inx, input int exp_lat, input int stall,
                          input bit pulse, input string name);
        int n;
        n = 0;
        while (!iacc64 && n < 200) begin
            @(negedge Clock);
            n++;
        end
        chk({name, "_idle"}, {63'h0, iacc64}, 64'd1);
        op64        = x;
        in_mode[0]  = mode;
        in_valid[0] = 1'b1;
        out_acc[0]  = 1'b0;
        @(negedge Clock);               // accept edge has passed
        in_valid[0] = 1'b0;
        op64        = ~x;
        in_mode[0]  = ~mode;
        n = 0;
        while (!oval64 && n < 200) begin
            in_valid[0] = (pulse && n == 5);
            @(negedge Clock);
            n++;
        end
        in_valid[0] = 1'b0;
        chk({name, "_latency"}, 64'(n), 64'(exp_lat));
        chk({name, "_result"}, {32'h0, res64}, {32'h0, exp_res});
        chk({name, "_inexact"}, {63'h0, inx64}, {63'h0, exp_inx});
        for (int i = 0; i < stall; i++) begin
            @(negedge Clock);
            chk({name, "_stall_result"}, {32'h0, res64}, {32'h0, exp_res});
            chk({name, "_stall_iacc"}, {63'h0, iacc64}, 64'd0);
            chk({name, "_stall_valid"}, {63'h0, oval64}, 64'd1);
        end
        out_acc[0] = 1'b1;
        @(negedge Clock);
        out_acc[0] = 1'b0;
        chk({name, "_iacc_after"}, {63'h0, iacc64}, 64'd1);
        chk({name, "_valid_after"}, {63'h0, oval64}, 64'd0);
    endtask

    // ------------------------------------------------------------------------
    // 16-bit instance: free-running random traffic with random stalls
    // ------------------------------------------------------------------------
    initial begin
        in_valid[1] = 1'b0;
        in_mode[1]  = 1'b0;
        out_acc[1]  = 1'b0;
        op16        = 16'h0;
        while (!stop16) begin
            @(negedge Clock);
            in_valid[1] = ($urandom % 3) != 0;
            in_mode[1]  = 1'($urandom % 2);
            op16        = rand16();
            out_acc[1]  = ($urandom % 4) != 0;
        end
        in_valid[1] = 1'b0;
        out_acc[1]  = 1'b1;
    end

    // Watchdog
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

    // ------------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------------
    initial begin
        in_valid[0] = 1'b0;
        in_mode[0]  = 1'b0;
        out_acc[0]  = 1'b0;
        op64        = 64'h0;

        // Pin the model with hand-computed values.
        chk("pin_4p0",       {32'h0, model_root(64'h0000_0004_0000_0000, 1'b0, 32)}, 64'h0002_0000);
        chk("pin_2p0_trunc", {32'h0, model_root(64'h0000_0002_0000_0000, 1'b0, 32)}, 64'h0001_6A09);
        chk("pin_2p0_round", {32'h0, model_root(64'h0000_0002_0000_0000, 1'b1, 32)}, 64'h0001_6A0A);
        chk("pin_max_round", {32'h0, model_root(64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 32)}, 64'hFFFF_FFFF);
        chk("pin_max16_round", {32'h0, model_root(64'hFFFF, 1'b1, 8)}, 64'hFF);
        chk("pin_2p0_inexact", {63'h0, model_inexact(64'h0000_0002_0000_0000)}, 64'd1);
        chk("pin_9_inexact",   {63'h0, model_inexact(64'd9)}, 64'd0);

        @(negedge Clock);
        @(negedge Clock);
        chk("rst_iacc",  {63'h0, iacc64}, 64'd1);
        chk("rst_valid", {63'h0, oval64}, 64'd0);
        chk("rst_result", {32'h0, res64}, 64'd0);
        chk("rst_inexact", {63'h0, inx64}, 64'd0);
        #2 Reset = 1'b1;
        @(negedge Clock);

        run_op(64'h0000_0004_0000_0000, 1'b0, 32'h0002_0000, 1'b0, 32, 0, 1'b0, "four");
        run_op(64'h0000_0002_0000_0000, 1'b0, 32'h0001_6A09, 1'b1, 32, 10, 1'b1, "two_trunc");
        run_op(64'h0000_0002_0000_0000, 1'b1, 32'h0001_6A0A, 1'b1, 33, 0, 1'b0, "two_round");
        run_op(64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 32'hFFFF_FFFF, 1'b1, 32, 0, 1'b0, "max_trunc");
        run_op(64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1, 33, 3, 1'b1, "max_round");
        run_op(64'h0, 1'b0, 32'h0, 1'b0, 32, 0, 1'b0, "zero_trunc");
        run_op(64'h0, 1'b1, 32'h0, 1'b0, 33, 0, 1'b0, "zero_round");

        // Reset in the middle of an operation.
        op64        = 64'h1234_5678_9ABC_DEF0;
        in_mode[0]  = 1'b0;
        in_valid[0] = 1'b1;
        @(negedge Clock);
        in_valid[0] = 1'b0;
        repeat (10) @(negedge Clock);
        chk("mid_busy", {63'h0, iacc64}, 64'd0);
        #2 Reset = 1'b0;
        #1;
        chk("mid_rst_iacc",    {63'h0, iacc64}, 64'd1);
        chk("mid_rst_valid",   {63'h0, oval64}, 64'd0);
        chk("mid_rst_result",  {32'h0, res64}, 64'd0);
        chk("mid_rst_inexact", {63'h0, inx64}, 64'd0);
        chk("mid_rst_result16", {56'h0, res16}, 64'd0);
        @(negedge Clock);
        @(negedge Clock);
        #2 Reset = 1'b1;
        @(negedge Clock);
        run_op(64'h0000_0009_0000_0000, 1'b0, 32'h0003_0000, 1'b0, 32, 0, 1'b0, "nine");

        // Randomized traffic on the 64-bit instance.
        for (int c = 0; c < 25000; c++) begin
            @(negedge Clock);
            in_valid[0] = ($urandom % 3) != 0;
            in_mode[0]  = 1'($urandom % 2);
            op64        = rand64();
            out_acc[0]  = ($urandom % 4) != 0;
        end
        in_valid[0] = 1'b0;
        out_acc[0]  = 1'b1;
        stop16      = 1'b1;
        repeat (50) @(negedge Clock);

        chk("ops64_completed", {63'h0, m_completed[0] > 300}, 64'd1);
        chk("ops16_completed", {63'h0, m_completed[1] > 1000}, 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fixed_point_sqrt_seq.md
# fixed_point_sqrt_seq

Parametrised, sequential unsigned fixed-point square-root unit for the arithmetic datapath. It accepts an unsigned radicand of `IN_WIDTH` bits and returns an `IN_WIDTH/2`-bit root. A Q(2m).(2f) radicand therefore yields a Q(m).(f) root without explicit rescaling. It computes one root bit per cycle with a restoring digit-by-digit recurrence, and adds a per-operation round-to-nearest mode, an inexact flag and two-sided valid/accept handshakes.

## Interface
- `IN_WIDTH`, default 64: radicand width. Must be even and ≥ 4.
- `OUT_WIDTH`, derived localparam `IN_WIDTH/2`: root width.
- `Clock`  in  1  rising-edge clock; all state changes on rising edges only.
- `Reset`  in  1  asynchronous, active-low; 0 forces the reset state immediately.
- `iOperand`  in  IN_WIDTH  unsigned radicand; sampled on the accept edge.
- `iRoundMode`  in  1  0 = truncate, 1 = round-to-nearest; sampled on the accept edge.
- `iInputValid`  in  1  upstream offers an operand.
- `oInputAccept`  out  1  unit is idle and takes an operand this cycle.
- `oOutputValid`  out  1  `oResult` and `oInexact` are valid.
- `iOutputAccept`  in  1  downstream consumes the result.
- `oResult`  out  OUT_WIDTH  root.
- `oInexact`  out  1  final remainder ≠ 0, i.e. the root is not exact.

## Operation
- States: IDLE, ITER, ROUND, DONE.
- IDLE:
  - `oInputAccept = 1`.
  - On `iInputValid=1`: latch the operand into the radicand shift register, latch `iRoundMode`, clear root and remainder, set counter = OUT_WIDTH−1, go to ITER.
- ITER, one step per cycle, MSB pair first:
  - remainder ← (remainder<<2) | next two radicand bits.
  - trial ← (root<<2) | 1.
  - If remainder ≥ trial: remainder −= trial and root ← (root<<1)|1; otherwise root ← root<<1.
  - Counter decrements each step. After the step at counter = 0, go to ROUND if the latched round mode is 1, else DONE.
- Remainder width is OUT_WIDTH+2 bits, which is sufficient for all inputs.
- ROUND:
  - If remainder > root, increment the root. This is exact nearest rounding because (r+½)² = r²+r+¼.
  - An increment from all-ones saturates to all-ones.
  - Go to DONE.
- DONE:
  - Hold `oOutputValid = 1`, with `oResult` and `oInexact` stable.
  - Inexact means the unrounded remainder ≠ 0; it is unaffected by saturation.
  - On `iOutputAccept=1`, go to IDLE.
- Ignored inputs: `iInputValid` outside IDLE; `iOutputAccept` outside DONE.
- Operands and `iRoundMode` may change freely after the accept edge.

## Timing
- Reset values: `oInputAccept=1`, `oOutputValid=0`, `oResult=0`, `oInexact=0`, state IDLE, internal registers 0.
- Let the accept edge be E0.
- Truncate mode:
  - `oOutputValid` rises after edge E(OUT_WIDTH).
  - Latency is OUT_WIDTH cycles (32 at the default width).
- Round mode: latency is OUT_WIDTH+1 cycles.
- Result consumption and throughput:
  - The result is consumed on the edge where `oOutputValid & iOutputAccept` holds.
  - `oOutputValid` falls and `oInputAccept` rises after that edge.
  - The earliest next accept is the following edge; there is no same-cycle turnaround.
  - Back-to-back throughput is one operation per latency+2 cycles.
- Output stalls: `oOutputValid` remains asserted indefinitely while `iOutputAccept=0`, with no data change.
- `Reset` asserted in any state:
  - Aborts the operation and returns all outputs to reset values asynchronously.
  - The first accept is possible on the first rising edge after deassertion.
- `oInputAccept` and `oOutputValid` are both registered state decodes, never combinational from inputs.

## Structure
- Shared package holds:
  - the state encoding constants (IDLE/ITER/ROUND/DONE);
  - the round-mode constants (TRUNC=0, NEAREST=1).
- Width localparams (OUT_WIDTH, remainder width, counter width = clog2(OUT_WIDTH)) stay local to the module.
- One natural combinational sub-module, `sqrt_restore_step`, parametrised by OUT_WIDTH:
  - inputs: remainder, root, 2-bit radicand slice;
  - outputs: next remainder, next root.
- Everything else (FSM, counter, shift register) stays in the top module.

## Test plan
- Default width. Each row gives the radicand, the mode, and the required `oResult` / `oInexact`:
  - `0x0000_0004_0000_0000` (4.0), truncate → `0x0002_0000`, inexact 0. `oOutputValid` rises exactly 32 cycles after the accept edge.
  - `0x0000_0002_0000_0000` (2.0), truncate → `0x0001_6A09`, inexact 1.
  - Same operand, round → `0x0001_6A0A`, inexact 1. Latency 33 cycles.
  - `0xFFFF_FFFF_FFFF_FFFF`, truncate → `0xFFFF_FFFF`, inexact 1.
  - Same operand, round → saturated `0xFFFF_FFFF`, inexact 1.
  - `0`, either mode → `0`, inexact 0.
- Handshake:
  - Hold `iOutputAccept=0` for 10 cycles in DONE → result stable and `oInputAccept=0` throughout.
  - Pulse `iInputValid` with a different operand while in ITER → ignored; result unchanged.
  - Then accept → `oInputAccept` rises next cycle.
- Reset mid-operation: assert `Reset=0` at ITER step 10 → outputs at reset values immediately. Release, submit 9.0 (`0x9_0000_0000`) → `0x0003_0000`.
- Randomized: 10k random operands and modes at IN_WIDTH=64 and IN_WIDTH=16, checked against a reference model.
  - Truncate: floor(√x).
  - Round: nearest, saturated.
  - Inexact = (floor² ≠ x).
  - Random downstream stalls on `iOutputAccept`.
